wshb_arbiter: RTL



---
 rtl/wshb_arbiter_pkg.sv | 40 ++++
 rtl/wshb_if.sv | 30 +++
 rtl/rr_pick.sv | 23 ++
 rtl/wshb_arbiter.sv | 104 ++++++++++
 4 files changed

// File: rtl/wshb_arbiter_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wshb_arbiter_pkg;

    localparam int unsigned NB_MASTERS = 2;
    localparam int unsigned ADR_W      = 32;
    localparam int unsigned DAT_W      = 32;
    localparam int unsigned SEL_W      = DAT_W / 8;
    localparam int unsigned CTI_W      = 3;
    localparam int unsigned BTE_W      = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    // Master-to-slave payload of one requester.
    typedef struct packed {
        logic             cyc;
        logic             stb;
        logic             we;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
        logic [SEL_W-1:0] sel;
        logic [CTI_W-1:0] cti;
        logic [BTE_W-1:0] bte;
    } wb_req_t;

    // Slave-to-master cycle termination.
    typedef struct packed {
        logic ack;
        logic err;
        logic rty;
    } wb_rsp_t;

    function automatic logic [NB_MASTERS-1:0] idx_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 bus bundle with master and slave views.
interface wshb_if #(
    parameter int unsigned DATA_BYTES = 4
) ();
    localparam int unsigned DW = 8 * DATA_BYTES;

    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [31:0]           adr;
    logic [DW-1:0]         dat_ms;
    logic [DW-1:0]         dat_sm;
    logic [DATA_BYTES-1:0] sel;
    logic [2:0]            cti;
    logic [1:0]            bte;
    logic                  ack;
    logic                  err;
    logic                  rty;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel, cti, bte,
        input  dat_sm, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
        output dat_sm, ack, err, rty
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin next-owner choice: a lone requester wins, a tie goes to the
// master that was not granted last.
module rr_pick
    import wshb_arbiter_pkg::*;
(
    input  logic cyc0_i,
    input  logic cyc1_i,
    input  logic last_i,
    output logic valid_c_o,
    output logic idx_c_o
);

    always_comb begin
        valid_c_o = cyc0_i | cyc1_i;
        idx_c_o   = 1'b0;
        if (cyc0_i && cyc1_i) begin
            idx_c_o = ~last_i;
        end else if (cyc1_i) begin
            idx_c_o = 1'b1;
        end
    end

endmodule

// File: rtl/wshb_arbiter.sv
// Two-master Wishbone arbiter: grants whole bus cycles round-robin and muxes
// the owner onto the shared SDRAM port.
module wshb_arbiter
    import wshb_arbiter_pkg::*;
#(
    parameter int unsigned NB_MASTERS = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    wshb_if.slave      wshb_ifs_0,
    wshb_if.slave      wshb_ifs_1,
    wshb_if.master     wshb_ifm,
    output logic [1:0] grant
);

    if (NB_MASTERS != 2) begin : g_nb_masters_check
        $error("wshb_arbiter supports exactly two masters");
    end

    arb_state_t state_q;
    logic       last_q;
    logic [1:0] grant_q;

    wb_req_t    req_0;
    wb_req_t    req_1;
    wb_req_t    req_m;
    wb_rsp_t    rsp_s;
    wb_rsp_t    rsp_0;
    wb_rsp_t    rsp_1;

    logic       pick_valid;
    logic       pick_idx;
    logic       hold;

    assign req_0 = {wshb_ifs_0.cyc, wshb_ifs_0.stb, wshb_ifs_0.we, wshb_ifs_0.adr,
                    wshb_ifs_0.dat_ms, wshb_ifs_0.sel, wshb_ifs_0.cti, wshb_ifs_0.bte};
    assign req_1 = {wshb_ifs_1.cyc, wshb_ifs_1.stb, wshb_ifs_1.we, wshb_ifs_1.adr,
                    wshb_ifs_1.dat_ms, wshb_ifs_1.sel, wshb_ifs_1.cti, wshb_ifs_1.bte};
    assign rsp_s = {wshb_ifm.ack, wshb_ifm.err, wshb_ifm.rty};

    rr_pick u_rr_pick (
        .cyc0_i    (req_0.cyc),
        .cyc1_i    (req_1.cyc),
        .last_i    (last_q),
        .valid_c_o (pick_valid),
        .idx_c_o   (pick_idx)
    );

    // An owner keeps the bus for as long as its own cyc stays high.
    assign hold = ((state_q == GNT0) && req_0.cyc) || ((state_q == GNT1) && req_1.cyc);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            grant_q <= 2'b00;
        end else if (!hold) begin
            if (pick_valid) begin
                state_q <= pick_idx ? GNT1 : GNT0;
                last_q  <= pick_idx;
                grant_q <= idx_onehot(pick_idx);
            end else begin
                state_q <= IDLE;
                grant_q <= 2'b00;
            end
        end
    end

    // Zero-latency forwarding decoded from the registered owner.
    always_comb begin
        req_m = '0;
        rsp_0 = '0;
        rsp_1 = '0;
        case (state_q)
            GNT0: begin
                req_m = req_0;
                rsp_0 = rsp_s;
            end
            GNT1: begin
                req_m = req_1;
                rsp_1 = rsp_s;
            end
            default: begin
            end
        endcase
    end

    assign wshb_ifm.cyc    = req_m.cyc;
    assign wshb_ifm.stb    = req_m.stb;
    assign wshb_ifm.we     = req_m.we;
    assign wshb_ifm.adr    = req_m.adr;
    assign wshb_ifm.dat_ms = req_m.dat;
    assign wshb_ifm.sel    = req_m.sel;
    assign wshb_ifm.cti    = req_m.cti;
    assign wshb_ifm.bte    = req_m.bte;

    assign {wshb_ifs_0.ack, wshb_ifs_0.err, wshb_ifs_0.rty} = rsp_0;
    assign {wshb_ifs_1.ack, wshb_ifs_1.err, wshb_ifs_1.rty} = rsp_1;
    assign wshb_ifs_0.dat_sm = wshb_ifm.dat_sm;
    assign wshb_ifs_1.dat_sm = wshb_ifm.dat_sm;

    assign grant = grant_q;

endmodule
